// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared constants and action decode for pipeline boundary registers
package pipe_stage_reg_pkg;

  localparam logic        RstEnable  = 1'b0;
  localparam logic        STOP       = 1'b1;
  localparam logic        NOSTOP     = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } stage_act_e;

  // Flush beats any stall; a stopped stage feeding a running one emits a bubble.
  function automatic stage_act_e decode_act(input logic flush,
                                            input logic stop_here,
                                            input logic stop_next);
    if (flush)
      return ACT_FLUSH;
    else if (stop_here == NOSTOP)
      return ACT_ADVANCE;
    else if (stop_next == STOP)
      return ACT_HOLD;
    else
      return ACT_BUBBLE;
  endfunction

endpackage

// File: rtl/pipe_lane_compact.sv
// rtl/pipe_lane_compact.sv - packs valid lanes toward lane 0 and reports the first valid lane
module pipe_lane_compact #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*DATA_W-1:0] i_data,
  input  logic [LANES-1:0]        i_valid,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic [LANES-1:0]        o_valid,
  output logic [IDX_W-1:0]        o_first
);

  always_comb begin
    int unsigned n;
    logic        seen;
    o_data  = '0;
    o_valid = '0;
    o_first = '0;
    n       = 0;
    seen    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (i_valid[i]) begin
        o_data[n*DATA_W +: DATA_W] = i_data[i*DATA_W +: DATA_W];
        o_valid[n] = 1'b1;
        if (!seen) begin
          o_first = IDX_W'(i);
          seen    = 1'b1;
        end
        n = n + 1;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - multi-lane pipeline boundary register with flush/bubble/hold and event counters
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LANES          = 2,
  parameter int STALL_W        = 6,
  parameter int STAGE          = 1,
  parameter int COMPACT        = 1,
  parameter int ZERO_ON_BUBBLE = 1,
  parameter int CNT_W          = 16
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       in_pc,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_valid,
  input  logic                    cnt_clr,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_valid,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  generate
    if ((STAGE + 1 >= STALL_W) || (LANES < 1) || (LANES > 4)) begin : g_bad_params
      $error("pipe_stage_reg: illegal STAGE/STALL_W/LANES combination");
    end
  endgenerate

  logic [LANES*DATA_W-1:0] w_cmp_data;
  logic [LANES-1:0]        w_cmp_valid;
  logic [IDX_W-1:0]        w_first;
  logic [ADDR_W-1:0]       w_nxt_pc;
  logic [LANES*DATA_W-1:0] w_nxt_data;
  logic [LANES-1:0]        w_nxt_valid;
  stage_act_e              w_act;

  logic [ADDR_W-1:0]       r_pc;
  logic [LANES*DATA_W-1:0] r_data;
  logic [LANES-1:0]        r_valid;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic [CNT_W-1:0]        r_bubble_cnt;
  logic [CNT_W-1:0]        r_flush_cnt;

  pipe_lane_compact #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_compact (
    .i_data  (in_data),
    .i_valid (in_valid),
    .o_data  (w_cmp_data),
    .o_valid (w_cmp_valid),
    .o_first (w_first)
  );

  assign w_act = decode_act(flush, stall[STAGE], stall[STAGE+1]);

  // With no valid lane w_first is 0, so the PC falls through unchanged.
  always_comb begin
    w_nxt_pc    = in_pc;
    w_nxt_data  = in_data;
    w_nxt_valid = in_valid;
    if (COMPACT != 0) begin
      w_nxt_pc    = in_pc + ADDR_W'(w_first) * ADDR_W'(INST_BYTES);
      w_nxt_data  = w_cmp_data;
      w_nxt_valid = w_cmp_valid;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n == RstEnable) begin
      r_pc    <= ADDR_W'(ZeroWord);
      r_data  <= '0;
      r_valid <= '0;
    end else begin
      case (w_act)
        ACT_FLUSH, ACT_BUBBLE: begin
          r_valid <= '0;
          if (ZERO_ON_BUBBLE != 0) begin
            r_pc   <= '0;
            r_data <= '0;
          end
        end
        ACT_ADVANCE: begin
          r_pc    <= w_nxt_pc;
          r_data  <= w_nxt_data;
          r_valid <= w_nxt_valid;
        end
        default: begin
        end
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge Clk) begin
    if ((Rst_n == RstEnable) || cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_act == ACT_HOLD)   r_stall_cnt  <= sat_inc(r_stall_cnt);
      if (w_act == ACT_BUBBLE) r_bubble_cnt <= sat_inc(r_bubble_cnt);
      if (w_act == ACT_FLUSH)  r_flush_cnt  <= sat_inc(r_flush_cnt);
    end
  end

  assign out_pc     = r_pc;
  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (positional and compacting variants)
module tb_pipe_stage_reg;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] in_pc;
  logic [63:0] in_data;
  logic [1:0]  in_valid;
  logic        cnt_clr;

  logic [31:0] a_pc, b_pc;
  logic [63:0] a_data, b_data;
  logic [1:0]  a_valid, b_valid;
  logic [15:0] a_st, a_bu, a_fl;
  logic [3:0]  b_st, b_bu, b_fl;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  // Variant A: positional lanes, zero payload on bubble, 16-bit counters.
  pipe_stage_reg #(.ADDR_W(32), .DATA_W(32), .LANES(2), .STALL_W(6), .STAGE(1),
                   .COMPACT(0), .ZERO_ON_BUBBLE(1), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .in_pc(in_pc),
    .in_data(in_data), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .out_pc(a_pc), .out_data(a_data), .out_valid(a_valid),
    .stall_cnt(a_st), .bubble_cnt(a_bu), .flush_cnt(a_fl));

  // Variant B: compacting lanes, payload kept on bubble, 4-bit counters.
  pipe_stage_reg #(.ADDR_W(32), .DATA_W(32), .LANES(2), .STALL_W(6), .STAGE(1),
                   .COMPACT(1), .ZERO_ON_BUBBLE(0), .CNT_W(4)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .in_pc(in_pc),
    .in_data(in_data), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .out_pc(b_pc), .out_data(b_data), .out_valid(b_valid),
    .stall_cnt(b_st), .bubble_cnt(b_bu), .flush_cnt(b_fl));

  // Reference model state, index 0 = variant A, 1 = variant B.
  logic [31:0] m_pc[2];
  logic [63:0] m_data[2];
  logic [1:0]  m_valid[2];
  int          m_st[2], m_bu[2], m_fl[2];
  int          m_max[2]  = '{65535, 15};
  bit          m_comp[2] = '{1'b0, 1'b1};
  bit          m_zob[2]  = '{1'b1, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!Rst_n) begin
        m_pc[k] = 0; m_data[k] = 0; m_valid[k] = 0;
        m_st[k] = 0; m_bu[k] = 0; m_fl[k] = 0;
      end else begin
        bit is_bubble, is_hold;
        is_bubble = !flush && stall[1] && !stall[2];
        is_hold   = !flush && stall[1] && stall[2];
        if (cnt_clr) begin
          m_st[k] = 0; m_bu[k] = 0; m_fl[k] = 0;
        end else if (flush)     m_fl[k] = sat(m_fl[k], m_max[k]);
        else if (is_bubble)     m_bu[k] = sat(m_bu[k], m_max[k]);
        else if (is_hold)       m_st[k] = sat(m_st[k], m_max[k]);

        if (flush || is_bubble) begin
          m_valid[k] = 0;
          if (m_zob[k]) begin m_pc[k] = 0; m_data[k] = 0; end
        end else if (!stall[1]) begin
          if (!m_comp[k]) begin
            m_pc[k] = in_pc; m_data[k] = in_data; m_valid[k] = in_valid;
          end else begin
            logic [31:0] q[$];
            int first;
            first = -1;
            for (int i = 0; i < 2; i++)
              if (in_valid[i]) begin
                q.push_back(in_data[i*32 +: 32]);
                if (first < 0) first = i;
              end
            m_pc[k] = (first < 0) ? in_pc : in_pc + 32'(4 * first);
            m_data[k] = 0; m_valid[k] = 0;
            for (int i = 0; i < q.size(); i++) begin
              m_data[k][i*32 +: 32] = q[i];
              m_valid[k][i] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("a_pc",     64'(a_pc),    64'(m_pc[0]));
    check("a_data",   a_data,       m_data[0]);
    check("a_valid",  64'(a_valid), 64'(m_valid[0]));
    check("a_stall",  64'(a_st),    64'(m_st[0]));
    check("a_bubble", 64'(a_bu),    64'(m_bu[0]));
    check("a_flush",  64'(a_fl),    64'(m_fl[0]));
    check("b_pc",     64'(b_pc),    64'(m_pc[1]));
    check("b_data",   b_data,       m_data[1]);
    check("b_valid",  64'(b_valid), 64'(m_valid[1]));
    check("b_stall",  64'(b_st),    64'(m_st[1]));
    check("b_bubble", 64'(b_bu),    64'(m_bu[1]));
    check("b_flush",  64'(b_fl),    64'(m_fl[1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  initial begin
    Rst_n = 1'b0; stall = 6'h3F; flush = 1'b1; cnt_clr = 1'b0;
    in_pc = 32'hDEAD_BEEF; in_data = 64'h1111_2222_3333_4444; in_valid = 2'b11;
    #1;
    tick();
    tick();
    check("rst_a_pc", 64'(a_pc), 64'h0);
    check("rst_a_valid", 64'(a_valid), 64'h0);
    check("rst_b_data", b_data, 64'h0);

    // Plain advance
    Rst_n = 1'b1; stall = 6'b000000; flush = 1'b0;
    in_pc = 32'h100; in_data = {32'h2, 32'h1}; in_valid = 2'b11;
    tick();
    check("adv_a_pc", 64'(a_pc), 64'h100);
    check("adv_a_data", a_data, {32'h2, 32'h1});
    check("adv_a_valid", 64'(a_valid), 64'h3);

    // Bubble, then hold
    stall = 6'b000010;
    tick();
    check("bub_a_valid", 64'(a_valid), 64'h0);
    check("bub_a_data", a_data, 64'h0);
    check("bub_a_cnt", 64'(a_bu), 64'd1);
    check("bub_b_keep", b_data, {32'h2, 32'h1});
    stall = 6'b000110;
    in_pc = 32'h555; in_data = 64'h9; in_valid = 2'b01;
    repeat (3) tick();
    check("hold_a_pc", 64'(a_pc), 64'h0);
    check("hold_a_cnt", 64'(a_st), 64'd3);

    // Flush overrides every stall
    stall = 6'b111111; flush = 1'b1;
    tick();
    check("fl_a_valid", 64'(a_valid), 64'h0);
    check("fl_a_cnt", 64'(a_fl), 64'd1);
    check("fl_a_stall", 64'(a_st), 64'd3);

    // Compaction of upper lane
    flush = 1'b0; stall = 6'b0;
    in_pc = 32'h200; in_data = {32'hABCD, 32'h1234}; in_valid = 2'b10;
    tick();
    check("cmp_b_valid", 64'(b_valid), 64'h1);
    check("cmp_b_data", b_data, 64'h0000_0000_0000_ABCD);
    check("cmp_b_pc", 64'(b_pc), 64'h204);
    check("cmp_a_valid", 64'(a_valid), 64'h2);

    // PC wrap
    in_pc = 32'hFFFF_FFFC;
    tick();
    check("wrap_b_pc", 64'(b_pc), 64'h0);

    // Empty capture is not a bubble
    in_valid = 2'b00; in_pc = 32'h40;
    tick();
    check("empty_b_pc", 64'(b_pc), 64'h40);
    check("empty_b_valid", 64'(b_valid), 64'h0);

    // Saturation on the 4-bit counters, then clear wins over increment
    stall = 6'b000110;
    repeat (20) tick();
    check("sat_b_stall", 64'(b_st), 64'd15);
    check("sat_a_stall", 64'(a_st), 64'd23);
    tick();
    check("sat_b_stay", 64'(b_st), 64'd15);
    cnt_clr = 1'b1;
    tick();
    check("clr_b_stall", 64'(b_st), 64'd0);
    check("clr_a_flush", 64'(a_fl), 64'd0);
    cnt_clr = 1'b0;

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      Rst_n    = ($urandom_range(0, 99) != 0);
      stall    = 6'($urandom);
      if ($urandom_range(0, 2) == 0) stall[1] = 1'b0;
      flush    = ($urandom_range(0, 9) == 0);
      cnt_clr  = ($urandom_range(0, 49) == 0);
      in_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      in_data  = {$urandom, $urandom};
      in_valid = 2'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
